// File: rtl/imm_pkg.sv
// Shared types for the immediate-decode stage: format codes, RV opcodes and the skid FSM states.
package imm_pkg;

  localparam int unsigned OPC_W = 7;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6,
    FMT_CSR  = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP        = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [OPC_W-1:0] OPC_OP_32     = 7'b0111011;

endpackage

// File: rtl/imm_gen_comb.sv
// Combinational RISC-V immediate generator: instruction -> extended immediate, format, illegal flag.
module imm_gen_comb
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned IW   = 32
) (
  input  logic [IW-1:0]   instr_i,
  output logic [XLEN-1:0] imm_c_o,
  output fmt_e            fmt_c_o,
  output logic            illegal_c_o
);

  logic [2:0] funct3;
  logic       is_shift;

  assign funct3   = instr_i[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    imm_c_o     = '0;
    fmt_c_o     = FMT_NONE;
    illegal_c_o = 1'b0;
    case (instr_i[6:0])
      OPC_LUI, OPC_AUIPC: begin
        fmt_c_o = FMT_U;
        imm_c_o = XLEN'($signed({instr_i[31:12], 12'b0}));
      end
      OPC_JAL: begin
        fmt_c_o = FMT_J;
        imm_c_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));
      end
      OPC_JALR, OPC_LOAD: begin
        fmt_c_o = FMT_I;
        imm_c_o = XLEN'($signed(instr_i[31:20]));
      end
      OPC_OP_IMM: begin
        fmt_c_o = FMT_I;
        // Shift amount field grows to 6 bits on RV64
        if (is_shift && (XLEN == 64)) imm_c_o = XLEN'(instr_i[25:20]);
        else if (is_shift)            imm_c_o = XLEN'(instr_i[24:20]);
        else                          imm_c_o = XLEN'($signed(instr_i[31:20]));
      end
      OPC_STORE: begin
        fmt_c_o = FMT_S;
        imm_c_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
      end
      OPC_BRANCH: begin
        fmt_c_o = FMT_B;
        imm_c_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
      end
      OPC_OP: fmt_c_o = FMT_R;
      OPC_SYSTEM: begin
        if (funct3 != 3'b000) begin
          fmt_c_o = FMT_CSR;
          imm_c_o = XLEN'(instr_i[19:15]);
        end
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          fmt_c_o = FMT_I;
          if (is_shift) imm_c_o = XLEN'(instr_i[24:20]);
          else          imm_c_o = XLEN'($signed(instr_i[31:20]));
        end else begin
          illegal_c_o = 1'b1;
        end
      end
      OPC_OP_32: begin
        if (XLEN == 64) fmt_c_o = FMT_R;
        else            illegal_c_o = 1'b1;
      end
      default: illegal_c_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Decode stage with a 2-entry skid buffer; entries are decoded once at the input and
// the decoded results are carried through the skid and output registers.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned IW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IW-1:0]   out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output fmt_e            out_fmt,
  output logic            out_illegal
);

  state_e          state_q;
  logic            in_ready_q, out_valid_q;
  logic [IW-1:0]   out_instr_q, skid_instr_q;
  logic [XLEN-1:0] out_pc_q, skid_pc_q, out_imm_q, skid_imm_q;
  fmt_e            out_fmt_q, skid_fmt_q;
  logic            out_illegal_q, skid_illegal_q;

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;
  logic            in_fire, out_fire;

  imm_gen_comb #(.XLEN(XLEN), .IW(IW)) u_gen (
    .instr_i     (in_instr),
    .imm_c_o     (dec_imm),
    .fmt_c_o     (dec_fmt),
    .illegal_c_o (dec_illegal)
  );

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  // Skid FSM; in_ready_q tracks the next state so it never depends on live inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_EMPTY;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_instr_q    <= '0;
      out_pc_q       <= '0;
      out_imm_q      <= '0;
      out_fmt_q      <= FMT_NONE;
      out_illegal_q  <= 1'b0;
      skid_instr_q   <= '0;
      skid_pc_q      <= '0;
      skid_imm_q     <= '0;
      skid_fmt_q     <= FMT_NONE;
      skid_illegal_q <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q <= 1'b1;
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            out_instr_q   <= in_instr;
            out_pc_q      <= in_pc;
            out_imm_q     <= dec_imm;
            out_fmt_q     <= dec_fmt;
            out_illegal_q <= dec_illegal;
            out_valid_q   <= 1'b1;
            state_q       <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && !out_fire) begin
            skid_instr_q   <= in_instr;
            skid_pc_q      <= in_pc;
            skid_imm_q     <= dec_imm;
            skid_fmt_q     <= dec_fmt;
            skid_illegal_q <= dec_illegal;
            state_q        <= ST_TWO;
            in_ready_q     <= 1'b0;
          end else if (in_fire) begin
            out_instr_q   <= in_instr;
            out_pc_q      <= in_pc;
            out_imm_q     <= dec_imm;
            out_fmt_q     <= dec_fmt;
            out_illegal_q <= dec_illegal;
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            out_instr_q   <= skid_instr_q;
            out_pc_q      <= skid_pc_q;
            out_imm_q     <= skid_imm_q;
            out_fmt_q     <= skid_fmt_q;
            out_illegal_q <= skid_illegal_q;
            state_q       <= ST_ONE;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter IW, default 32, instruction width; fixed at 32.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 flush  in  1  discard all held and incoming entries.
REQ-006 in_valid  in  1  fetch entry valid.
REQ-007 in_ready  out  1  stage can accept; driven from registered state only.
REQ-008 in_instr  in  IW  raw instruction.
REQ-009 in_pc  in  XLEN  instruction PC.
REQ-010 out_valid  out  1  decoded entry valid.
REQ-011 out_ready  in  1  consumer accepts.
REQ-012 out_instr / out_pc  out  IW / XLEN  pass-through of the accepted entry.
REQ-013 out_imm  out  XLEN  extended immediate.
REQ-014 out_fmt  out  3  format code, imm_pkg::fmt_e.
REQ-015 out_illegal  out  1  opcode not decodable for this XLEN.

Function
REQ-016 Transfer occurs on valid&&ready, per side; a held output entry stays stable until taken.
REQ-017 Latency: an entry accepted in cycle N is presented at the output in cycle N+1.
REQ-018 Opcode->format: LUI/AUIPC=U; JAL=J; JALR/LOAD/OP-IMM=I; STORE=S; BRANCH=B; OP=R; SYSTEM funct3!=0=CSR; SYSTEM funct3==0=NONE; OP-IMM-32 (0011011) and OP-32 (0111011) are I/R when XLEN=64, otherwise illegal.
REQ-019 Immediates are sign-extended from instr[31] to XLEN: I {instr[31:20]}; S {instr[31:25],instr[11:7]}; B {instr[31],instr[7],instr[30:25],instr[11:8],0}; J {instr[31],instr[19:12],instr[20],instr[30:21],0}; U {instr[31:12],12'b0}, sign-extended above bit 31.
REQ-020 OP-IMM shifts (funct3 001/101): imm is shamt zero-extended — instr[24:20] for XLEN=32 or OP-IMM-32, instr[25:20] for XLEN=64.
REQ-021 CSR: imm is instr[19:15] (zimm) zero-extended.
REQ-022 R, NONE, illegal: imm=0; illegal sets out_illegal=1 and fmt NONE.
REQ-023 Buffering: 2-entry skid; FSM EMPTY, ONE (output register full), TWO (output and skid full).
REQ-024 EMPTY: accept -> ONE.
REQ-025 ONE: accept only -> TWO if !out_ready, else stays ONE; take only -> EMPTY; accept and take -> ONE.
REQ-026 TWO: take -> ONE, skid moves to output next cycle.
REQ-027 in_ready=1 in EMPTY and ONE, 0 in TWO.
REQ-028 Order is preserved; no entry is dropped or duplicated except by flush.
REQ-029 flush takes priority: next state EMPTY and any simultaneous input handshake is discarded; out_valid=0 the following cycle.

Reset
REQ-030 While rst=1: state EMPTY; out_valid=0; in_ready=0; out_imm, out_pc and out_instr are 0; out_fmt=NONE; out_illegal=0 — all asynchronously.
REQ-031 rst asserted mid-operation discards all entries; in_ready=1 from the first clock edge after deassertion.

Structure
REQ-032 Package imm_pkg holds fmt_e (NONE,R,I,S,B,U,J,CSR), the opcode localparams and the state enum.
REQ-033 The combinational decode is sub-module imm_gen_comb (instr -> imm, fmt, illegal, parameter XLEN); it is instantiated once at the input, and both skid and output registers store its decoded results.

Verification
REQ-034 XLEN=32, instr 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_imm=0xFFFFFFFF, fmt I, illegal=0.
REQ-035 instr 0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFC, fmt B.
REQ-036 XLEN=64, instr 0x03F09093 (slli x1,x1,63) -> out_imm=63, fmt I; same instr with XLEN=32 -> imm=31. With XLEN=32, opcode 0011011 -> illegal=1, imm=0.
REQ-037 in_valid held for 6 consecutive entries with out_ready=0 for 3 cycles -> exactly 2 accepted, in_ready=0 until out_ready rises, and all 6 entries emerge in order.
REQ-038 In state TWO, flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed entries never appear.
REQ-039 rst pulsed asynchronously between edges in state TWO -> out_valid falls immediately without a clock edge; csrrwi x0,0x300,31 issued after reset -> fmt CSR, imm=31.
